// File: rtl/pdm_rx_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_rx_ctrl
//
// Capture sequencer between the PDM decimation front-end and the uDMA RX
// channel. A start pulse latches the capture configuration and enables the
// front-end. The first cfg_discard_i samples (CIC warm-up) are dropped. The
// remaining samples are turned into 32-bit words and queued in a small FIFO
// toward the uDMA. Capture ends after cfg_num_samples_i kept samples, or on a
// stop pulse. The block then flushes and pulses done_o.
//
// Build option (macro PDM_RX_PACK_EN):
//   defined   : two 16-bit samples per word, first sample in [15:0], second in
//               [31:16]. A half-filled word is flushed with [31:16]=0 when the
//               capture ends.
//   undefined : one word per sample, laid out as {14'b0, ch_idx, sample}. There
//               is no partial-word flush.
//
// Parameters:
//   FIFO_DEPTH  output word FIFO entries (power of 2, >= 2)
//   CNT_WIDTH   width of the sample-count configuration and counter
//   DISC_WIDTH  width of the discard-count configuration
//
// Ports:
//   clk_i              clock
//   rstn_i             asynchronous active-low reset
//   cfg_start_i        start pulse; configuration latched on acceptance
//   cfg_stop_i         stop pulse
//   cfg_ch_mode_i      00=1ch, 01/10=2ch, 11=4ch
//   cfg_discard_i      number of samples dropped after enable
//   cfg_num_samples_i  number of samples to capture, 0 = continuous
//   pdm_en_o           front-end enable
//   pcm_data_i         PCM sample
//   pcm_valid_i        PCM sample strobe
//   pcm_ready_o        high outside IDLE (informational; front-end cannot stall)
//   data_o             word toward uDMA (0 while the FIFO is empty)
//   data_valid_o       FIFO not empty
//   data_ready_i       uDMA accepts the word
//   ch_idx_o           channel index of the last accepted sample
//   busy_o             sequencer not idle
//   done_o             one-cycle completion pulse
//   overflow_o         sticky word-drop flag
// -----------------------------------------------------------------------------
module pdm_rx_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int DISC_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_start_i,
    input  logic                  cfg_stop_i,
    input  logic [1:0]            cfg_ch_mode_i,
    input  logic [DISC_WIDTH-1:0] cfg_discard_i,
    input  logic [CNT_WIDTH-1:0]  cfg_num_samples_i,
    output logic                  pdm_en_o,
    input  logic [15:0]           pcm_data_i,
    input  logic                  pcm_valid_i,
    output logic                  pcm_ready_o,
    output logic [31:0]           data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [1:0]            ch_idx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Latched configuration and progress counters
    logic [1:0]            mode_q;
    logic [DISC_WIDTH-1:0] disc_cnt_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  smp_cnt_q;
    logic [CNT_WIDTH-1:0]  smp_cnt_inc;
    logic [1:0]            ch_next_q;
    logic [1:0]            ch_idx_q;
    logic [1:0]            ch_mask;
    logic                  overflow_q;

    // Word FIFO
    logic [31:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    // Word producer
    logic                  push_req;
    logic                  push_ok;
    logic [31:0]           push_word;
    logic                  pack_pending;

    // Decoded events
    logic                  start_acc;
    logic                  sample_in;
    logic                  run_sample;
    logic                  last_discard;
    logic                  count_hit;
    logic                  drain_empty;

    assign start_acc    = (state_q == IDLE) && cfg_start_i;
    assign sample_in    = pcm_valid_i && ((state_q == SETTLE) || (state_q == RUN));
    assign run_sample   = pcm_valid_i && (state_q == RUN);
    assign last_discard = pcm_valid_i && (state_q == SETTLE) &&
                          (disc_cnt_q == DISC_WIDTH'(1));
    assign smp_cnt_inc  = smp_cnt_q + 1'b1;
    assign count_hit    = run_sample && (num_q != '0) && (smp_cnt_inc == num_q);

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign pop          = !fifo_empty && data_ready_i;
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still lands when the uDMA takes a word at the same time.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign drain_empty  = fifo_empty && !pack_pending;

    // The channel counter wraps at the number of interleaved channels.
    always_comb begin
        ch_mask = 2'd0;
        case (mode_q)
            2'b00:         ch_mask = 2'd0;
            2'b01, 2'b10:  ch_mask = 2'd1;
            default:       ch_mask = 2'd3;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = (cfg_discard_i == '0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                if (cfg_stop_i) begin
                    state_d = DRAIN;
                end else if (last_discard) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cfg_stop_i || count_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pdm_en_o    = 1'b0;
        busy_o      = 1'b0;
        pcm_ready_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            SETTLE, RUN: begin
                pdm_en_o    = 1'b1;
                busy_o      = 1'b1;
                pcm_ready_o = 1'b1;
            end
            DRAIN: begin
                busy_o      = 1'b1;
                pcm_ready_o = 1'b1;
                done_o      = drain_empty;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration latch, discard / sample counters, channel tracking,
    // sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q     <= 2'b00;
            disc_cnt_q <= '0;
            num_q      <= '0;
            smp_cnt_q  <= '0;
            ch_next_q  <= 2'd0;
            ch_idx_q   <= 2'd0;
            overflow_q <= 1'b0;
        end else if (start_acc) begin
            mode_q     <= cfg_ch_mode_i;
            disc_cnt_q <= cfg_discard_i;
            num_q      <= cfg_num_samples_i;
            smp_cnt_q  <= '0;
            ch_next_q  <= 2'd0;
            ch_idx_q   <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            // Discarded samples still advance the channel index so that the
            // first kept sample carries its true channel position.
            if (sample_in) begin
                ch_idx_q  <= ch_next_q;
                ch_next_q <= (ch_next_q + 2'd1) & ch_mask;
            end
            if (pcm_valid_i && (state_q == SETTLE)) begin
                disc_cnt_q <= disc_cnt_q - 1'b1;
            end
            if (run_sample) begin
                smp_cnt_q <= smp_cnt_inc;
            end
            if (push_req && !push_ok && (state_q == RUN)) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef PDM_RX_PACK_EN
    logic        pack_half_q;
    logic [15:0] pack_lo_q;

    assign pack_pending = pack_half_q;

    // Even samples wait in pack_lo_q; odd samples complete the word. In
    // DRAIN a waiting half word goes out with a zero upper half.
    always_comb begin
        push_req  = 1'b0;
        push_word = 32'h0;
        if (run_sample && pack_half_q) begin
            push_req  = 1'b1;
            push_word = {pcm_data_i, pack_lo_q};
        end else if ((state_q == DRAIN) && pack_half_q) begin
            push_req  = 1'b1;
            push_word = {16'h0000, pack_lo_q};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pack_half_q <= 1'b0;
            pack_lo_q   <= 16'h0000;
        end else if (start_acc) begin
            pack_half_q <= 1'b0;
            pack_lo_q   <= 16'h0000;
        end else if (run_sample) begin
            if (!pack_half_q) begin
                pack_lo_q   <= pcm_data_i;
                pack_half_q <= 1'b1;
            end else begin
                // Word is pushed or dropped; either way the pair is done.
                pack_half_q <= 1'b0;
            end
        end else if ((state_q == DRAIN) && pack_half_q && push_ok) begin
            pack_half_q <= 1'b0;
        end
    end
`else
    assign pack_pending = 1'b0;

    // One word per sample, tagged with the channel index of that sample.
    always_comb begin
        push_req  = 1'b0;
        push_word = 32'h0;
        if (run_sample) begin
            push_req  = 1'b1;
            push_word = {14'b0, ch_next_q, pcm_data_i};
        end
    end
`endif

    // ------------------------------------------------------------------
    // Word FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign data_valid_o = !fifo_empty;
    assign data_o       = fifo_empty ? 32'h0 : mem[rd_ptr_q];
    assign ch_idx_o     = ch_idx_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_pdm_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdm_rx_ctrl
//
// Self-checking bench for pdm_rx_ctrl. A cycle-by-cycle vector table covers
// a basic packed capture, hand-written sequences cover discard, overflow,
// simultaneous push/pop, stop and reset, and a randomized section checks the
// word stream against expectations computed from the sample list. Honours
// the PDM_RX_PACK_EN build option.
// -----------------------------------------------------------------------------
module tb_pdm_rx_ctrl;

    localparam int CNT_WIDTH  = 16;
    localparam int DISC_WIDTH = 8;

`ifdef PDM_RX_PACK_EN
    localparam int PER_WORD = 2;
`else
    localparam int PER_WORD = 1;
`endif

    logic                  clk_i = 1'b0;
    logic                  rstn_i = 1'b0;
    logic                  cfg_start_i = 1'b0;
    logic                  cfg_stop_i = 1'b0;
    logic [1:0]            cfg_ch_mode_i = 2'b00;
    logic [DISC_WIDTH-1:0] cfg_discard_i = '0;
    logic [CNT_WIDTH-1:0]  cfg_num_samples_i = '0;
    logic                  pdm_en_o;
    logic [15:0]           pcm_data_i = 16'h0;
    logic                  pcm_valid_i = 1'b0;
    logic                  pcm_ready_o;
    logic [31:0]           data_o;
    logic                  data_valid_o;
    logic                  data_ready_i = 1'b0;
    logic [1:0]            ch_idx_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;

    pdm_rx_ctrl #(
        .FIFO_DEPTH (2),
        .CNT_WIDTH  (CNT_WIDTH),
        .DISC_WIDTH (DISC_WIDTH)
    ) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .cfg_start_i       (cfg_start_i),
        .cfg_stop_i        (cfg_stop_i),
        .cfg_ch_mode_i     (cfg_ch_mode_i),
        .cfg_discard_i     (cfg_discard_i),
        .cfg_num_samples_i (cfg_num_samples_i),
        .pdm_en_o          (pdm_en_o),
        .pcm_data_i        (pcm_data_i),
        .pcm_valid_i       (pcm_valid_i),
        .pcm_ready_o       (pcm_ready_o),
        .data_o            (data_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .ch_idx_o          (ch_idx_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected word stream, and the kept samples it is built from
    logic [31:0] exp_q[$];
    logic [15:0] kept_q[$];
    logic [1:0]  kept_ch[$];
    bit          mon_en = 1'b0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [15:0] data;
        logic        en;
        logic        busy;
        logic        dv;
        logic [31:0] dout;
        logic        done;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(logic st, logic v, logic [15:0] d, logic en,
                                logic busy, logic dv, logic [31:0] dout,
                                logic done);
        vec_t r;
        r.start = st;
        r.valid = v;
        r.data  = d;
        r.en    = en;
        r.busy  = busy;
        r.dv    = dv;
        r.dout  = dout;
        r.done  = done;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        cfg_start_i = v.start;
        pcm_valid_i = v.valid;
        pcm_data_i  = v.data;
    endtask

    // Turn the kept sample list into the words the uDMA should see.
    task automatic pushExpected();
`ifdef PDM_RX_PACK_EN
        for (int i = 0; i < kept_q.size(); i += 2) begin
            if (i + 1 < kept_q.size()) exp_q.push_back({kept_q[i+1], kept_q[i]});
            else                       exp_q.push_back({16'h0000, kept_q[i]});
        end
`else
        for (int i = 0; i < kept_q.size(); i++) begin
            exp_q.push_back({14'b0, kept_ch[i], kept_q[i]});
        end
`endif
        kept_q.delete();
        kept_ch.delete();
    endtask

    task automatic startCapture(input logic [1:0] mode, input int disc, input int num);
        cfg_ch_mode_i     = mode;
        cfg_discard_i     = DISC_WIDTH'(disc);
        cfg_num_samples_i = CNT_WIDTH'(num);
        cfg_start_i       = 1'b1;
        tick();
        cfg_start_i       = 1'b0;
    endtask

    task automatic stopCapture();
        cfg_stop_i = 1'b1;
        tick();
        cfg_stop_i = 1'b0;
    endtask

    task automatic sendSample(input logic [15:0] d);
        pcm_valid_i = 1'b1;
        pcm_data_i  = d;
        tick();
        pcm_valid_i = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        checkOutput({name, "_busy_after"}, 32'(busy_o), 32'd0);
        checkOutput({name, "_done_width"}, 32'(done_o), 32'd0);
        checkOutput({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Word scoreboard: a word is taken at the next edge when valid and ready.
    always @(negedge clk_i) begin
        if (mon_en && rstn_i && data_valid_o && data_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_word: got %h expected none", data_o);
            end else begin
                checkOutput("word", data_o, exp_q.pop_front());
            end
        end
    end

    // Random capture whose expected words come from the sample list alone.
    task automatic randomRun();
        logic [1:0]  mode;
        int          disc, num, k, nch, cap, nacc;
        bit          use_stop;
        logic [15:0] s[$];
        mode = 2'($urandom_range(0, 3));
        disc = $urandom_range(0, 4);
        num  = $urandom_range(0, 6);
        k    = $urandom_range(0, 10);
        nch  = (mode == 2'b00) ? 1 : ((mode == 2'b11) ? 4 : 2);
        cap  = (num == 0) ? 1000 : disc + num;
        use_stop = (k < cap);
        nacc = use_stop ? k : cap;
        s.delete();
        for (int i = 0; i < nacc; i++) s.push_back(16'($urandom));
        for (int i = disc; i < nacc; i++) begin
            kept_q.push_back(s[i]);
            kept_ch.push_back(2'(i % nch));
        end
        pushExpected();
        startCapture(mode, disc, num);
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        for (int i = 0; i < nacc; i++) begin
            sendSample(s[i]);
            if (use_stop || i != nacc - 1)
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        if (use_stop) stopCapture();
        waitDone("rand");
        checkOutput("rand_ch_idx", 32'(ch_idx_o),
                    (nacc > 0) ? 32'((nacc - 1) % nch) : 32'd0);
        checkOutput("rand_overflow", 32'(overflow_o), 32'd0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        data_ready_i = 1'b1;
        tick();
        tick();
        checkOutput("rst_pdm_en", 32'(pdm_en_o), 0);
        checkOutput("rst_busy", 32'(busy_o), 0);
        checkOutput("rst_dv", 32'(data_valid_o), 0);
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_done", 32'(done_o), 0);
        checkOutput("rst_ovf", 32'(overflow_o), 0);
        checkOutput("rst_ready", 32'(pcm_ready_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // ---------------- table: 1ch, discard 0, num 4 ----------------
        cfg_ch_mode_i     = 2'b00;
        cfg_discard_i     = '0;
        cfg_num_samples_i = CNT_WIDTH'(4);
        vecs[0] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vecs[1] = mk(1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef PDM_RX_PACK_EN
        vecs[2] = mk(1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vecs[3] = mk(1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 32'h22221111, 1'b0);
        vecs[4] = mk(1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vecs[5] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h44443333, 1'b0);
`else
        vecs[2] = mk(1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 32'h00001111, 1'b0);
        vecs[3] = mk(1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 32'h00002222, 1'b0);
        vecs[4] = mk(1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, 32'h00003333, 1'b0);
        vecs[5] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00004444, 1'b0);
`endif
        vecs[6] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        vecs[7] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk_i);
            checkOutput($sformatf("tbl%0d_pdm_en", i), 32'(pdm_en_o), 32'(vecs[i].en));
            checkOutput($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
            checkOutput($sformatf("tbl%0d_dv", i), 32'(data_valid_o), 32'(vecs[i].dv));
            checkOutput($sformatf("tbl%0d_data", i), data_o, vecs[i].dout);
            checkOutput($sformatf("tbl%0d_done", i), 32'(done_o), 32'(vecs[i].done));
            checkOutput($sformatf("tbl%0d_ch", i), 32'(ch_idx_o), 32'd0);
            tick();
        end
        applyStimulus(mk(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
        mon_en = 1'b1;

        // ---------------- 4ch, discard 3, num 5 ----------------
        for (int i = 3; i < 8; i++) begin
            kept_q.push_back(16'hA000 + 16'(i));
            kept_ch.push_back(2'(i % 4));
        end
        pushExpected();
        startCapture(2'b11, 3, 5);
        for (int i = 0; i < 8; i++) begin
            sendSample(16'hA000 + 16'(i));
            if (i == 3) checkOutput("disc_first_kept_ch", 32'(ch_idx_o), 32'd3);
            if (i == 7) checkOutput("disc_en_low", 32'(pdm_en_o), 32'd0);
            else        tick();
        end
        waitDone("disc");

        // ---------------- overflow with uDMA stalled ----------------
        data_ready_i = 1'b0;
        for (int i = 0; i < 2 * PER_WORD; i++) begin
            kept_q.push_back(16'hB001 + 16'(i));
            kept_ch.push_back(2'd0);
        end
        pushExpected();
        startCapture(2'b00, 0, 0);
        for (int i = 0; i < 6; i++) begin
            sendSample(16'hB001 + 16'(i));
            tick();
        end
        checkOutput("ovf_set", 32'(overflow_o), 32'd1);
        checkOutput("ovf_dv", 32'(data_valid_o), 32'd1);
        data_ready_i = 1'b1;
        stopCapture();
        waitDone("ovf");
        checkOutput("ovf_sticky", 32'(overflow_o), 32'd1);

        // ---------------- full FIFO, push with same-cycle pop ----------------
        data_ready_i = 1'b0;
        for (int i = 0; i < 3 * PER_WORD; i++) begin
            kept_q.push_back(16'hC001 + 16'(i));
            kept_ch.push_back(2'd0);
        end
        pushExpected();
        startCapture(2'b00, 0, 0);
        checkOutput("ovf_cleared_by_start", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 3 * PER_WORD - 1; i++) begin
            sendSample(16'hC001 + 16'(i));
            tick();
        end
        checkOutput("full_dv", 32'(data_valid_o), 32'd1);
        data_ready_i = 1'b1;
        sendSample(16'hC001 + 16'(3 * PER_WORD - 1));
        checkOutput("full_no_ovf", 32'(overflow_o), 32'd0);
        tick();
        stopCapture();
        waitDone("full");
        checkOutput("full_no_ovf_end", 32'(overflow_o), 32'd0);

        // ---------------- stop after 3 samples ----------------
        for (int i = 0; i < 3; i++) begin
            kept_q.push_back(16'hD001 + 16'(i));
            kept_ch.push_back(2'd0);
        end
        pushExpected();
        startCapture(2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            sendSample(16'hD001 + 16'(i));
            tick();
        end
        stopCapture();
        checkOutput("stop_en_low", 32'(pdm_en_o), 32'd0);
        waitDone("stop");
        stopCapture();
        checkOutput("idle_stop_busy", 32'(busy_o), 32'd0);
        checkOutput("idle_stop_en", 32'(pdm_en_o), 32'd0);

        // ---------------- reset mid-RUN ----------------
        mon_en       = 1'b0;
        data_ready_i = 1'b0;
        startCapture(2'b01, 0, 0);
        for (int i = 0; i < 3 * PER_WORD; i++) begin
            sendSample(16'hE001 + 16'(i));
            tick();
        end
        checkOutput("mid_ovf_pre", 32'(overflow_o), 32'd1);
        checkOutput("mid_ch_pre", 32'(ch_idx_o), 32'(((3 * PER_WORD) - 1) % 2));
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("mid_rst_en", 32'(pdm_en_o), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("mid_rst_dv", 32'(data_valid_o), 32'd0);
        checkOutput("mid_rst_data", data_o, 32'd0);
        checkOutput("mid_rst_ovf", 32'(overflow_o), 32'd0);
        checkOutput("mid_rst_ch", 32'(ch_idx_o), 32'd0);
        checkOutput("mid_rst_ready", 32'(pcm_ready_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        tick();
        checkOutput("post_rst_busy", 32'(busy_o), 32'd0);
        checkOutput("post_rst_dv", 32'(data_valid_o), 32'd0);

        // ---------------- randomized captures ----------------
        exp_q.delete();
        data_ready_i = 1'b1;
        mon_en       = 1'b1;
        for (int it = 0; it < 30; it++) begin
            randomRun();
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
